id_stage: RTL and testbench

Instruction-decode pipeline stage that sits directly upstream of `regfile`. It takes fetched RV64I instructions over a valid/ready handshake and registers them. It drives the register-file read addresses together with the decoded destination, the sign-extended immediate and the control bundle to the execute stage. It detects load-use hazards against the instruction it currently holds and inserts exactly one bubble per hazard.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/id_stage_if.sv | 43 ++++
 rtl/id_stage_imm_gen.sv | 27 ++
 rtl/id_stage.sv | 99 +++++++++
 tb/tb_id_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : RV64I decode constants, ALU-op encodings and control bundle
// Rev 1.0
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       branch;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decodeCtrl(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_R:      begin c.regWrite = 1'b1; c.aluOp = ALUOP_R; end
      OP_IMM:    begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALUOP_I; end
      OP_LOAD:   begin
        c.regWrite = 1'b1; c.memRead = 1'b1; c.memToReg = 1'b1;
        c.aluSrc   = 1'b1; c.aluOp   = ALUOP_ADD;
      end
      OP_STORE:  begin c.memWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALUOP_ADD; end
      OP_BRANCH: begin c.branch = 1'b1; c.aluOp = ALUOP_SUB; end
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Only these formats actually read rs2; I-type bits [24:20] are immediate.
  function automatic logic usesRs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// id_stage_if : fetch-side handshake plus decoded bundle toward execute
// Rev 1.0
// ============================================================================
interface id_stage_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      readReg1;
  logic [4:0]      readReg2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_funct;
  logic            regWrite;
  logic            memRead;
  logic            memWrite;
  logic            memToReg;
  logic            aluSrc;
  logic            branch;
  logic [1:0]      aluOp;
  logic            illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, readReg1, readReg2, out_rd, out_imm,
           out_funct, regWrite, memRead, memWrite, memToReg, aluSrc, branch,
           aluOp, illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, readReg1, readReg2, out_rd, out_imm,
           out_funct, regWrite, memRead, memWrite, memToReg, aluSrc, branch,
           aluOp, illegal
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// imm_gen : combinational sign-extended immediate for I/load, S and B formats
// Rev 1.0
// ============================================================================
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  wire logic [31:0]     inst,
  output logic      [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OP_STORE:        imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:       imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                              inst[30:25], inst[11:8], 1'b0};
      default:         imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// id_stage : RV64I decode pipeline register with load-use bubble insertion
// Rev 1.0
// ============================================================================
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   flush,
  id_stage_if.slave   bus
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_hazard;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_funct;
  ctrl_t           r_ctrl;

  assign w_opcode = bus.in_inst[6:0];
  assign w_rs1    = bus.in_inst[19:15];
  assign w_rs2    = bus.in_inst[24:20];
  assign w_ctrl   = decodeCtrl(w_opcode);

  imm_gen #(.XLEN(XLEN)) u_immGen (
    .inst (bus.in_inst),
    .imm  (w_imm)
  );

  // Held load whose result the offered instruction needs: stall one cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (r_valid && r_ctrl.memRead && (r_rd != 5'd0)) begin
      w_hazard = (!w_ctrl.illegal && (w_rs1 == r_rd)) ||
                 (usesRs2(w_opcode) && (w_rs2 == r_rd));
    end
  end

  assign bus.in_ready = (!r_valid || bus.out_ready) && !w_hazard && !flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_funct <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= bus.in_pc;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= bus.in_inst[11:7];
      r_imm   <= w_imm;
      r_funct <= {bus.in_inst[30], bus.in_inst[14:12]};
      r_ctrl  <= w_ctrl;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.readReg1  = r_rs1;
  assign bus.readReg2  = r_rs2;
  assign bus.out_rd    = r_rd;
  assign bus.out_imm   = r_imm;
  assign bus.out_funct = r_funct;
  assign bus.regWrite  = r_ctrl.regWrite;
  assign bus.memRead   = r_ctrl.memRead;
  assign bus.memWrite  = r_ctrl.memWrite;
  assign bus.memToReg  = r_ctrl.memToReg;
  assign bus.aluSrc    = r_ctrl.aluSrc;
  assign bus.branch    = r_ctrl.branch;
  assign bus.aluOp     = r_ctrl.aluOp;
  assign bus.illegal   = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// tb_id_stage : directed decode vectors plus hazard, stall, flush, reset cases
// Rev 1.0
// ============================================================================
module tb_id_stage;

  logic clk;
  logic reset;
  logic flush;

  id_stage_if #(.XLEN(64)) bus ();

  id_stage #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0], illegal}
  logic [8:0] ctrlAct;
  assign ctrlAct = {bus.regWrite, bus.memRead, bus.memWrite, bus.memToReg,
                    bus.aluSrc, bus.branch, bus.aluOp, bus.illegal};

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [3:0]  funct;
    logic [8:0]  ctrl;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int nVec = 0;
  int nMis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0] = '{32'h002081B3, 64'h1000, 5'd1,  5'd2,  5'd3,  64'h0,                4'h0, 9'b100000100}; // add x3,x1,x2
    vecs[1] = '{32'h0080B283, 64'h1004, 5'd1,  5'd8,  5'd5,  64'h8,                4'h3, 9'b110110000}; // ld x5,8(x1)
    vecs[2] = '{32'hFE20BC23, 64'h1008, 5'd1,  5'd2,  5'd24, 64'hFFFFFFFFFFFFFFF8, 4'hB, 9'b001010000}; // sd x2,-8(x1)
    vecs[3] = '{32'hFE208EE3, 64'h100C, 5'd1,  5'd2,  5'd29, 64'hFFFFFFFFFFFFFFFC, 4'h8, 9'b000001010}; // beq x1,x2,-4
    vecs[4] = '{32'hFFF58513, 64'h1010, 5'd11, 5'd31, 5'd10, 64'hFFFFFFFFFFFFFFFF, 4'h8, 9'b100010110}; // addi x10,x11,-1
    vecs[5] = '{32'h409403B3, 64'h1014, 5'd8,  5'd9,  5'd7,  64'h0,                4'h8, 9'b100000100}; // sub x7,x8,x9
    vecs[6] = '{32'h0000007F, 64'h1018, 5'd0,  5'd0,  5'd0,  64'h0,                4'h0, 9'b000000001}; // illegal opcode
    vecs[7] = '{32'h00419863, 64'h101C, 5'd3,  5'd4,  5'd16, 64'h10,               4'h1, 9'b000001010}; // bne x3,x4,+16

    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 64'h0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset readReg1",  64'(bus.readReg1),  64'h0);
    chk("reset readReg2",  64'(bus.readReg2),  64'h0);
    chk("reset ctrl",      64'(ctrlAct),       64'h0);
    chk("reset imm",       bus.out_imm,        64'h0);
    chk("reset in_ready",  64'(bus.in_ready),  64'h1);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = vecs[i].pc;
      #1 chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'h1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'h1);
      chk($sformatf("v%0d pc", i),        bus.out_pc,         vecs[i].pc);
      chk($sformatf("v%0d readReg1", i),  64'(bus.readReg1),  64'(vecs[i].rs1));
      chk($sformatf("v%0d readReg2", i),  64'(bus.readReg2),  64'(vecs[i].rs2));
      chk($sformatf("v%0d rd", i),        64'(bus.out_rd),    64'(vecs[i].rd));
      chk($sformatf("v%0d imm", i),       bus.out_imm,        vecs[i].imm);
      chk($sformatf("v%0d funct", i),     64'(bus.out_funct), 64'(vecs[i].funct));
      chk($sformatf("v%0d ctrl", i),      64'(ctrlAct),       64'(vecs[i].ctrl));
    end

    // Load-use: ld x5 then add x6,x5,x7 back-to-back -> one bubble.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = 32'h0080B283; bus.in_pc = 64'h2000;
    @(negedge clk);
    chk("hz ld valid",   64'(bus.out_valid), 64'h1);
    chk("hz ld memRead", 64'(bus.memRead),   64'h1);
    chk("hz ld imm",     bus.out_imm,        64'h8);
    bus.in_inst = 32'h00728333; bus.in_pc = 64'h2004;
    #1 chk("hz stall in_ready", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    chk("hz bubble out_valid", 64'(bus.out_valid), 64'h0);
    chk("hz retry in_ready",   64'(bus.in_ready),  64'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hz add valid",    64'(bus.out_valid), 64'h1);
    chk("hz add readReg1", 64'(bus.readReg1),  64'h5);
    chk("hz add readReg2", 64'(bus.readReg2),  64'h7);
    chk("hz add rd",       64'(bus.out_rd),    64'h6);

    // Back-pressure holds the bundle, then flush kills it and the offered inst.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_inst = 32'h002081B3; bus.in_pc = 64'h3000;
    @(negedge clk);
    bus.in_inst = 32'h409403B3; bus.in_pc = 64'h3004;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d in_ready", k), 64'(bus.in_ready), 64'h0);
      chk($sformatf("stall%0d valid", k), 64'(bus.out_valid), 64'h1);
      chk($sformatf("stall%0d rd", k),    64'(bus.out_rd),    64'h3);
      chk($sformatf("stall%0d pc", k),    bus.out_pc,         64'h3000);
      chk($sformatf("stall%0d ctrl", k),  64'(ctrlAct),       64'(9'b100000100));
      @(negedge clk);
    end
    flush = 1'b1;
    #1 chk("flush in_ready", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    chk("flush out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush no accept", 64'(bus.out_rd),    64'h3);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // Reset asserted mid-stall: no bubble carried into the restart.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = 32'h0080B283; bus.in_pc = 64'h4000;
    @(negedge clk);
    bus.in_inst = 32'h00728333; bus.in_pc = 64'h4004;
    #1 chk("rst pre in_ready", 64'(bus.in_ready), 64'h0);
    #2 reset = 1'b0;
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst readReg1",  64'(bus.readReg1),  64'h0);
    chk("rst memRead",   64'(bus.memRead),   64'h0);
    chk("rst rd",        64'(bus.out_rd),    64'h0);
    chk("rst in_ready",  64'(bus.in_ready),  64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post-rst valid",    64'(bus.out_valid), 64'h1);
    chk("post-rst readReg1", 64'(bus.readReg1),  64'h5);
    chk("post-rst readReg2", 64'(bus.readReg2),  64'h7);
    chk("post-rst pc",       bus.out_pc,         64'h4004);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
